// File: rtl/input_conditioner_if.sv
// input_conditioner_if: groups raw board inputs, the SoC acknowledge and the conditioned PIO outputs.
//   master: board/SoC side, drives sw_i, key_n_i and key_ack_i and receives the conditioned levels.
//   slave : the conditioner, receives the raw inputs and drives the export/press/pending outputs.
interface input_conditioner_if #(
    parameter int NSW   = 8,
    parameter int NKEYS = 2
);
    logic [NSW-1:0]   sw_i;
    logic [NKEYS-1:0] key_n_i;
    logic [NKEYS-1:0] key_ack_i;
    logic [NSW-1:0]   sw_export;
    logic [NKEYS-1:0] key_level_export;
    logic [NKEYS-1:0] key_press_o;
    logic [NKEYS-1:0] key_pend_export;

    modport master (
        output sw_i, key_n_i, key_ack_i,
        input  sw_export, key_level_export, key_press_o, key_pend_export
    );

    modport slave (
        input  sw_i, key_n_i, key_ack_i,
        output sw_export, key_level_export, key_press_o, key_pend_export
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces switches/keys, emits press pulses and sticky pending flags.
//   clk_clk     : system clock
//   reset_reset : synchronous active-high reset
//   bus (slave) : raw sw_i/key_n_i/key_ack_i in; sw_export, key_level_export, key_press_o, key_pend_export out
module input_conditioner #(
    parameter int NSW             = 8,
    parameter int NKEYS           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic               clk_clk,
    input logic               reset_reset,
    input_conditioner_if.slave bus
);
    localparam int NB = NSW + NKEYS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw, sync1, sync2, stable;
    logic [NKEYS-1:0] stable_d, press, pend;
    logic [CW-1:0]    cnt [NB];

    // keys are inverted up front so every internal bit is active-high
    assign raw = {~bus.key_n_i, bus.sw_i};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
            press    <= '0;
            pend     <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable[NB-1:NSW];
            press    <= stable[NB-1:NSW] & ~stable_d;
            // a press in the same cycle as an ack keeps the flag set
            pend     <= press | (pend & ~bus.key_ack_i);
        end
    end

    // any return to the stable value before terminal count discards the partial count
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (reset_reset) begin
                stable[i] <= 1'b0;
                cnt[i]    <= '0;
            end else if (sync2[i] == stable[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == TERM) begin
                stable[i] <= sync2[i];
                cnt[i]    <= '0;
            end else begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    assign bus.sw_export        = stable[NSW-1:0];
    assign bus.key_level_export = stable[NB-1:NSW];
    assign bus.key_press_o      = press;
    assign bus.key_pend_export  = pend;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;
    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    input_conditioner_if #(.NSW(8), .NKEYS(2)) bus ();

    input_conditioner #(.NSW(8), .NKEYS(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    task automatic tick();
        @(negedge clk_clk);
    endtask

    task automatic test_reset();
        reset_reset   = 1'b1;
        bus.sw_i      = 8'hFF;
        bus.key_n_i   = 2'b00;
        bus.key_ack_i = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({bus.sw_export, bus.key_level_export, bus.key_press_o, bus.key_pend_export} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got sw=%h lvl=%b prs=%b pend=%b, want all 0",
                         c, bus.sw_export, bus.key_level_export, bus.key_press_o, bus.key_pend_export);
            end
        end
        bus.sw_i    = 8'h00;
        bus.key_n_i = 2'b11;
        tick();
        tick();
        tick();
        reset_reset = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if ({bus.sw_export, bus.key_level_export, bus.key_pend_export} !== 12'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got sw=%h lvl=%b pend=%b, want 0",
                     bus.sw_export, bus.key_level_export, bus.key_pend_export);
        end
    endtask

    task automatic test_switch();
        bus.sw_i = 8'hA5;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (bus.sw_export !== 8'h00) begin
                errors++;
                $display("FAIL sw_early edge %0d: got %h want 00", c, bus.sw_export);
            end
        end
        tick();
        checks++;
        if (bus.sw_export !== 8'hA5) begin
            errors++;
            $display("FAIL sw_latency edge 6: got %h want A5", bus.sw_export);
        end
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (bus.sw_export !== 8'hA5 || bus.key_level_export !== 2'b00) begin
            errors++;
            $display("FAIL sw_hold: got sw=%h lvl=%b want A5/00", bus.sw_export, bus.key_level_export);
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            bus.key_n_i[0] = ((c / 2) % 2 == 1);
            tick();
            checks++;
            if (bus.key_level_export[0] !== 1'b0 || bus.key_press_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_quiet cycle %0d: got lvl=%b prs=%b want 0/0",
                         c, bus.key_level_export[0], bus.key_press_o[0]);
            end
        end
        bus.key_n_i[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (bus.key_level_export[0] !== 1'b0) begin
                errors++;
                $display("FAIL key_early edge %0d: got %b want 0", c, bus.key_level_export[0]);
            end
        end
        tick();
        checks++;
        if (bus.key_level_export[0] !== 1'b1 || bus.key_press_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL key_level_rise: got lvl=%b prs=%b want 1/0", bus.key_level_export[0], bus.key_press_o[0]);
        end
        tick();
        checks++;
        if (bus.key_press_o !== 2'b01) begin
            errors++;
            $display("FAIL key_press_pulse: got %b want 01", bus.key_press_o);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (bus.key_press_o !== 2'b00 || bus.key_pend_export !== 2'b01 || bus.key_level_export !== 2'b01) begin
                errors++;
                $display("FAIL key_after_press cycle %0d: got prs=%b pend=%b lvl=%b want 00/01/01",
                         c, bus.key_press_o, bus.key_pend_export, bus.key_level_export);
            end
        end
    endtask

    task automatic test_glitch();
        bus.key_n_i[1] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) bus.key_n_i[1] = 1'b1;
            tick();
            checks++;
            if (bus.key_level_export[1] !== 1'b0 || bus.key_press_o[1] !== 1'b0 || bus.key_pend_export[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_key1 cycle %0d: got lvl=%b prs=%b pend=%b want 0/0/0",
                         c, bus.key_level_export[1], bus.key_press_o[1], bus.key_pend_export[1]);
            end
        end
    endtask

    task automatic test_pend();
        bus.key_n_i[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (bus.key_press_o !== 2'b00 || bus.key_pend_export !== 2'b01) begin
                errors++;
                $display("FAIL release_no_pulse edge %0d: got prs=%b pend=%b want 00/01",
                         c, bus.key_press_o, bus.key_pend_export);
            end
        end
        checks++;
        if (bus.key_level_export !== 2'b00) begin
            errors++;
            $display("FAIL release_level: got %b want 00", bus.key_level_export);
        end
        bus.key_ack_i = 2'b01;
        tick();
        bus.key_ack_i = 2'b00;
        checks++;
        if (bus.key_pend_export !== 2'b00) begin
            errors++;
            $display("FAIL ack_clear_first: got %b want 00", bus.key_pend_export);
        end
        bus.key_n_i[0] = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        checks++;
        if (bus.key_press_o !== 2'b01 || bus.key_pend_export !== 2'b00) begin
            errors++;
            $display("FAIL second_press: got prs=%b pend=%b want 01/00", bus.key_press_o, bus.key_pend_export);
        end
        bus.key_ack_i = 2'b01;
        tick();
        checks++;
        if (bus.key_pend_export !== 2'b01) begin
            errors++;
            $display("FAIL set_wins: got %b want 01", bus.key_pend_export);
        end
        tick();
        checks++;
        if (bus.key_pend_export !== 2'b00) begin
            errors++;
            $display("FAIL ack_alone: got %b want 00", bus.key_pend_export);
        end
        bus.key_ack_i = 2'b00;
        tick();
        checks++;
        if (bus.key_pend_export !== 2'b00) begin
            errors++;
            $display("FAIL ack_release_hold: got %b want 00", bus.key_pend_export);
        end
    endtask

    task automatic test_reset_midcount();
        bus.sw_i = 8'hAD;
        tick();
        tick();
        tick();
        reset_reset = 1'b1;
        tick();
        checks++;
        if ({bus.sw_export, bus.key_level_export, bus.key_press_o, bus.key_pend_export} !== 14'h0) begin
            errors++;
            $display("FAIL midcount_reset: got sw=%h lvl=%b prs=%b pend=%b want all 0",
                     bus.sw_export, bus.key_level_export, bus.key_press_o, bus.key_pend_export);
        end
        reset_reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (bus.sw_export !== 8'h00 || bus.key_level_export !== 2'b00) begin
                errors++;
                $display("FAIL redebounce_early edge %0d: got sw=%h lvl=%b want 00/00",
                         c, bus.sw_export, bus.key_level_export);
            end
        end
        tick();
        checks++;
        if (bus.sw_export !== 8'hAD || bus.key_level_export !== 2'b01 || bus.key_press_o !== 2'b00) begin
            errors++;
            $display("FAIL redebounce_rise: got sw=%h lvl=%b prs=%b want AD/01/00",
                     bus.sw_export, bus.key_level_export, bus.key_press_o);
        end
        tick();
        checks++;
        if (bus.key_press_o !== 2'b01) begin
            errors++;
            $display("FAIL held_key_pulse: got %b want 01", bus.key_press_o);
        end
        tick();
        checks++;
        if (bus.key_press_o !== 2'b00 || bus.key_pend_export !== 2'b01) begin
            errors++;
            $display("FAIL held_key_single: got prs=%b pend=%b want 00/01", bus.key_press_o, bus.key_pend_export);
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_bounce();
        test_glitch();
        test_pend();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
